// File: rtl/control_unit_pkg.sv
// Shared types for the K&S processor control path: instruction decode, FSM states,
// ALU op codes and the packed strobe bundle driven by the control unit.
package control_unit_pkg;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;

  typedef enum logic [3:0] {
    FETCH_1 = 4'd0,
    FETCH_2 = 4'd1,
    DECODE  = 4'd2,
    LOAD_1  = 4'd3,
    LOAD_2  = 4'd4,
    STORE_1 = 4'd5,
    EXEC    = 4'd6,
    BRANCH  = 4'd7,
    HALTED  = 4'd8
  } ctrl_state_t;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_AND = 2'b10;
  localparam logic [OP_W-1:0] OP_OR  = 2'b11;

  typedef struct packed {
    logic            branch;
    logic            pc_enable;
    logic            ir_enable;
    logic            addr_sel;
    logic            c_sel;
    logic [OP_W-1:0] operation;
    logic            write_reg_enable;
    logic            flags_reg_enable;
    logic            ram_write_enable;
    logic            halt;
  } ctrl_out_t;

  function automatic logic is_branch_instr(input decoded_instruction_type ins);
    return (ins inside {I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV});
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control/status bundle between control_unit (master) and data_path (slave).
interface control_unit_if
  import control_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) ();

  decoded_instruction_type decoded_instruction;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;

  logic                    branch;
  logic                    pc_enable;
  logic                    ir_enable;
  logic                    addr_sel;
  logic                    c_sel;
  logic [OP_W-1:0]         operation;
  logic                    write_reg_enable;
  logic                    flags_reg_enable;
  logic                    ram_write_enable;
  logic                    halt;
  logic [CNT_W-1:0]        instr_retired;

  modport master (
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halt, instr_retired
  );

  modport slave (
    output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halt, instr_retired
  );

endinterface

// File: rtl/control_unit_branch_cond.sv
// Combinational branch-condition evaluator: decides whether the current branch is taken.
module control_unit_branch_cond
  import control_unit_pkg::*;
#(
  parameter bit OV_FLAG_SIGNED = 1'b0
) (
  input  decoded_instruction_type i_decoded_instruction,
  input  logic                    i_zero_op,
  input  logic                    i_neg_op,
  input  logic                    i_unsigned_overflow,
  input  logic                    i_signed_overflow,
  output logic                    o_take_c
);

  logic w_ov;

  assign w_ov = OV_FLAG_SIGNED ? i_signed_overflow : i_unsigned_overflow;

  always_comb begin
    o_take_c = 1'b0;
    case (i_decoded_instruction)
      I_BRANCH: o_take_c = 1'b1;
      I_BZERO:  o_take_c = i_zero_op;
      I_BNZERO: o_take_c = ~i_zero_op;
      I_BNEG:   o_take_c = i_neg_op;
      I_BNNEG:  o_take_c = ~i_neg_op;
      I_BOV:    o_take_c = w_ov;
      I_BNOV:   o_take_c = ~w_ov;
      default:  o_take_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// K&S processor control FSM: sequences fetch/decode/execute and drives all datapath strobes.
// Strobes are registered from the next state, so each state's outputs appear during that state.
module control_unit
  import control_unit_pkg::*;
#(
  parameter bit          OV_FLAG_SIGNED = 1'b0,
  parameter int unsigned CNT_W          = 16
) (
  input logic            clk,
  input logic            rst_n,
  control_unit_if.master ctrl
);

  ctrl_state_t      r_state;
  ctrl_state_t      w_state_nxt;
  ctrl_out_t        r_out;
  ctrl_out_t        w_out_nxt;
  logic [CNT_W-1:0] r_instr_retired;
  logic             w_take_c;

  control_unit_branch_cond #(
    .OV_FLAG_SIGNED(OV_FLAG_SIGNED)
  ) u_branch_cond (
    .i_decoded_instruction(ctrl.decoded_instruction),
    .i_zero_op            (ctrl.zero_op),
    .i_neg_op             (ctrl.neg_op),
    .i_unsigned_overflow  (ctrl.unsigned_overflow),
    .i_signed_overflow    (ctrl.signed_overflow),
    .o_take_c             (w_take_c)
  );

  // Next state, then the strobe pattern that state will present once entered
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = '0;

    case (r_state)
      FETCH_1: w_state_nxt = FETCH_2;
      FETCH_2: w_state_nxt = DECODE;
      DECODE: begin
        case (ctrl.decoded_instruction)
          I_LOAD:                             w_state_nxt = LOAD_1;
          I_STORE:                            w_state_nxt = STORE_1;
          I_ADD, I_SUB, I_AND, I_OR, I_MOVE:  w_state_nxt = EXEC;
          I_HALT:                             w_state_nxt = HALTED;
          default: w_state_nxt = is_branch_instr(ctrl.decoded_instruction) ? BRANCH : FETCH_1;
        endcase
      end
      LOAD_1:  w_state_nxt = LOAD_2;
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = FETCH_1;
    endcase

    case (w_state_nxt)
      FETCH_2: w_out_nxt.ir_enable = 1'b1;
      DECODE:  w_out_nxt.pc_enable = 1'b1;
      LOAD_1:  w_out_nxt.addr_sel  = 1'b1;
      LOAD_2: begin
        w_out_nxt.addr_sel         = 1'b1;
        w_out_nxt.c_sel            = 1'b1;
        w_out_nxt.write_reg_enable = 1'b1;
      end
      STORE_1: begin
        w_out_nxt.addr_sel         = 1'b1;
        w_out_nxt.ram_write_enable = 1'b1;
      end
      EXEC: begin
        w_out_nxt.write_reg_enable = 1'b1;
        case (ctrl.decoded_instruction)
          I_ADD: begin w_out_nxt.operation = OP_ADD; w_out_nxt.flags_reg_enable = 1'b1; end
          I_SUB: begin w_out_nxt.operation = OP_SUB; w_out_nxt.flags_reg_enable = 1'b1; end
          I_AND: begin w_out_nxt.operation = OP_AND; w_out_nxt.flags_reg_enable = 1'b1; end
          I_OR:  begin w_out_nxt.operation = OP_OR;  w_out_nxt.flags_reg_enable = 1'b1; end
          // MOVE passes A through A|A and leaves the flags untouched
          default: w_out_nxt.operation = OP_OR;
        endcase
      end
      BRANCH: begin
        if (w_take_c) begin
          w_out_nxt.pc_enable = 1'b1;
          w_out_nxt.branch    = 1'b1;
          w_out_nxt.addr_sel  = 1'b1;
        end
      end
      HALTED:  w_out_nxt.halt = 1'b1;
      default: w_out_nxt = '0;
    endcase
  end

  // State, strobes and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= FETCH_1;
      r_out           <= '0;
      r_instr_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      if (r_state == DECODE && r_instr_retired != {CNT_W{1'b1}}) begin
        r_instr_retired <= r_instr_retired + CNT_W'(1);
      end
    end
  end

  assign ctrl.branch           = r_out.branch;
  assign ctrl.pc_enable        = r_out.pc_enable;
  assign ctrl.ir_enable        = r_out.ir_enable;
  assign ctrl.addr_sel         = r_out.addr_sel;
  assign ctrl.c_sel            = r_out.c_sel;
  assign ctrl.operation        = r_out.operation;
  assign ctrl.write_reg_enable = r_out.write_reg_enable;
  assign ctrl.flags_reg_enable = r_out.flags_reg_enable;
  assign ctrl.ram_write_enable = r_out.ram_write_enable;
  assign ctrl.halt             = r_out.halt;
  assign ctrl.instr_retired    = r_instr_retired;

  a_one_writer: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({r_out.write_reg_enable, r_out.ram_write_enable, r_out.ir_enable}));

  a_branch_pc: assert property (@(posedge clk) disable iff (!rst_n)
    r_out.branch |-> r_out.pc_enable);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a per-instruction cycle-table model checks every strobe each cycle
// for both overflow-flag selections, plus a narrow-counter instance for saturation.
module tb_control_unit;
  import control_unit_pkg::*;

  typedef struct packed {
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       addr_sel;
    logic       c_sel;
    logic [1:0] operation;
    logic       write_reg_enable;
    logic       flags_reg_enable;
    logic       ram_write_enable;
    logic       halt;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   cnt = 0;

  always #5 clk = ~clk;

  control_unit_if #(.CNT_W(16)) if_a ();
  control_unit_if #(.CNT_W(16)) if_b ();
  control_unit_if #(.CNT_W(2))  if_c ();

  control_unit #(.OV_FLAG_SIGNED(1'b0), .CNT_W(16)) u_a (.clk(clk), .rst_n(rst_n), .ctrl(if_a));
  control_unit #(.OV_FLAG_SIGNED(1'b1), .CNT_W(16)) u_b (.clk(clk), .rst_n(rst_n), .ctrl(if_b));
  control_unit #(.OV_FLAG_SIGNED(1'b0), .CNT_W(2))  u_c (.clk(clk), .rst_n(rst_n), .ctrl(if_c));

  outs_t w_a, w_b;
  assign w_a = {if_a.branch, if_a.pc_enable, if_a.ir_enable, if_a.addr_sel, if_a.c_sel,
                if_a.operation, if_a.write_reg_enable, if_a.flags_reg_enable,
                if_a.ram_write_enable, if_a.halt};
  assign w_b = {if_b.branch, if_b.pc_enable, if_b.ir_enable, if_b.addr_sel, if_b.c_sel,
                if_b.operation, if_b.write_reg_enable, if_b.flags_reg_enable,
                if_b.ram_write_enable, if_b.halt};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Cycle k of an instruction: 0=first fetch, 1=IR capture, 2=decode, 3.. execute
  function automatic outs_t exp_out(input decoded_instruction_type ins, input int k,
                                    input logic z, input logic n, input logic uo,
                                    input logic so, input bit ovs);
    outs_t o;
    logic  ov;
    logic  take;
    o  = '0;
    ov = ovs ? so : uo;
    case (ins)
      I_BRANCH: take = 1'b1;
      I_BZERO:  take = z;
      I_BNZERO: take = !z;
      I_BNEG:   take = n;
      I_BNNEG:  take = !n;
      I_BOV:    take = ov;
      I_BNOV:   take = !ov;
      default:  take = 1'b0;
    endcase
    if (k == 1) o.ir_enable = 1'b1;
    else if (k == 2) o.pc_enable = 1'b1;
    else if (k >= 3) begin
      if (ins == I_HALT) o.halt = 1'b1;
      else if (k == 3) begin
        case (ins)
          I_LOAD:  o.addr_sel = 1'b1;
          I_STORE: begin o.addr_sel = 1'b1; o.ram_write_enable = 1'b1; end
          I_ADD:   begin o.operation = 2'd0; o.write_reg_enable = 1'b1; o.flags_reg_enable = 1'b1; end
          I_SUB:   begin o.operation = 2'd1; o.write_reg_enable = 1'b1; o.flags_reg_enable = 1'b1; end
          I_AND:   begin o.operation = 2'd2; o.write_reg_enable = 1'b1; o.flags_reg_enable = 1'b1; end
          I_OR:    begin o.operation = 2'd3; o.write_reg_enable = 1'b1; o.flags_reg_enable = 1'b1; end
          I_MOVE:  begin o.operation = 2'd3; o.write_reg_enable = 1'b1; end
          default: if (take) begin o.pc_enable = 1'b1; o.branch = 1'b1; o.addr_sel = 1'b1; end
        endcase
      end else if (k == 4 && ins == I_LOAD) begin
        o.addr_sel = 1'b1;
        o.c_sel = 1'b1;
        o.write_reg_enable = 1'b1;
      end
    end
    return o;
  endfunction

  function automatic int cyc_len(input decoded_instruction_type ins);
    case (ins)
      I_LOAD:  return 5;
      I_NOP:   return 3;
      I_HALT:  return 23;
      default: return 4;
    endcase
  endfunction

  task automatic drive(input decoded_instruction_type ins, input logic z, input logic n,
                       input logic uo, input logic so);
    if_a.decoded_instruction = ins; if_b.decoded_instruction = ins; if_c.decoded_instruction = ins;
    if_a.zero_op = z;  if_b.zero_op = z;  if_c.zero_op = z;
    if_a.neg_op = n;   if_b.neg_op = n;   if_c.neg_op = n;
    if_a.unsigned_overflow = uo; if_b.unsigned_overflow = uo; if_c.unsigned_overflow = uo;
    if_a.signed_overflow = so;   if_b.signed_overflow = so;   if_c.signed_overflow = so;
  endtask

  task automatic check_counters(input int e);
    int ec;
    ec = (e > 3) ? 3 : e;
    check("retired_a", 32'(if_a.instr_retired), 32'(e));
    check("retired_b", 32'(if_b.instr_retired), 32'(e));
    check("retired_c_sat", 32'(if_c.instr_retired), 32'(ec));
  endtask

  // Called at the negedge where the FSM sits in its first fetch cycle
  task automatic run_instr(input decoded_instruction_type ins, input logic z, input logic n,
                           input logic uo, input logic so, input bit abort);
    int len;
    len = cyc_len(ins);
    drive(ins, z, n, uo, so);
    for (int k = 0; k < len; k++) begin
      check($sformatf("%s_k%0d_ov0", ins.name(), k), 32'(w_a), 32'(exp_out(ins, k, z, n, uo, so, 1'b0)));
      check($sformatf("%s_k%0d_ov1", ins.name(), k), 32'(w_b), 32'(exp_out(ins, k, z, n, uo, so, 1'b1)));
      check_counters((k >= 3) ? cnt + 1 : cnt);
      if (abort && k == len - 1) begin
        #2 rst_n = 1'b0;
        #1;
        check("abort_outs_a", 32'(w_a), 32'(0));
        check("abort_outs_b", 32'(w_b), 32'(0));
        check_counters(0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        return;
      end
      @(negedge clk);
    end
    cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    decoded_instruction_type ins;
    drive(I_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs_a", 32'(w_a), 32'(0));
    check("reset_outs_b", 32'(w_b), 32'(0));
    check_counters(0);
    rst_n = 1'b1;

    repeat (3) run_instr(I_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(I_LOAD,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(I_SUB,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(I_MOVE,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(I_BZERO, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(I_BZERO, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(I_BOV,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_instr(I_BNOV,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_instr(I_STORE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      ins = decoded_instruction_type'(4'($urandom_range(0, 14)));
      run_instr(ins, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    run_instr(I_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;

    run_instr(I_NOP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(I_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_instr(I_ADD,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(I_BNEG, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr(I_NOP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
